// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe
//   Pipelined 4-op ALU (ADD/SUB/AND/XOR) with valid/ready handshakes on both
//   sides and a ZF/SF/OF condition-code register that updates when a result
//   marked set_cc is accepted by the consumer.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   STAGES  pipeline register stages, 1 or 2 (= latency in cycles)
//
// Ports
//   clk        in   clock, all state changes on posedge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  block accepts a beat this cycle
//   control    in   op: 0 ADD, 1 SUB, 2 AND, 3 XOR
//   a, b       in   operands
//   set_cc     in   beat updates condition codes when accepted at output
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result this cycle
//   out        out  result
//   overflow   out  signed overflow of this result beat (0 for AND/XOR)
//   cc_zf      out  registered zero flag
//   cc_sf      out  registered sign flag
//   cc_of      out  registered overflow flag

module alu_cc_pipe #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    op_e op;
    assign op = op_e'(control);

    // ------------------------------------------------------------------
    // Stage-1 arithmetic
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_of;

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = a + b;
                alu_of  = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_of  = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_res_q,   s1_res_d;
    logic             s1_of_q,    s1_of_d;
    logic             s1_cc_q,    s1_cc_d;
    logic             s1_moves;
    logic             in_accept;

    // Stage 1 loads when empty or when its beat leaves this cycle; this
    // path is combinational through out_ready so a full pipe can stream.
    assign in_ready  = !s1_valid_q || s1_moves;
    assign in_accept = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_of_d    = s1_of_q;
        s1_cc_d    = s1_cc_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_accept) begin
            s1_res_d = alu_res;
            s1_of_d  = alu_of;
            s1_cc_d  = set_cc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_of_q    <= 1'b0;
            s1_cc_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_of_q    <= s1_of_d;
            s1_cc_q    <= s1_cc_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 2 and output selection
    // ------------------------------------------------------------------
    logic             last_valid;
    logic [WIDTH-1:0] last_res;
    logic             last_of;
    logic             last_cc;

    generate
        if (STAGES == 1) begin : g_one_stage
            assign s1_moves   = s1_valid_q && out_ready;
            assign last_valid = s1_valid_q;
            assign last_res   = s1_res_q;
            assign last_of    = s1_of_q;
            assign last_cc    = s1_cc_q;
        end else begin : g_two_stage
            logic             s2_valid_q, s2_valid_d;
            logic [WIDTH-1:0] s2_res_q,   s2_res_d;
            logic             s2_of_q,    s2_of_d;
            logic             s2_cc_q,    s2_cc_d;
            logic             s2_load;

            assign s2_load  = !s2_valid_q || out_ready;
            assign s1_moves = s1_valid_q && s2_load;

            always_comb begin
                s2_valid_d = s2_valid_q;
                s2_res_d   = s2_res_q;
                s2_of_d    = s2_of_q;
                s2_cc_d    = s2_cc_q;
                if (s2_load) begin
                    s2_valid_d = s1_valid_q;
                end
                // Payload only follows real beats, so out does not wander
                // while the pipe drains.
                if (s1_moves) begin
                    s2_res_d = s1_res_q;
                    s2_of_d  = s1_of_q;
                    s2_cc_d  = s1_cc_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_res_q   <= '0;
                    s2_of_q    <= 1'b0;
                    s2_cc_q    <= 1'b0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_res_q   <= s2_res_d;
                    s2_of_q    <= s2_of_d;
                    s2_cc_q    <= s2_cc_d;
                end
            end

            assign last_valid = s2_valid_q;
            assign last_res   = s2_res_q;
            assign last_of    = s2_of_q;
            assign last_cc    = s2_cc_q;
        end
    endgenerate

    assign out_valid = last_valid;
    assign out       = last_res;
    assign overflow  = last_of;

    // ------------------------------------------------------------------
    // Condition-code register
    // ------------------------------------------------------------------
    logic zf_q, zf_d;
    logic sf_q, sf_d;
    logic of_q, of_d;
    logic out_fire;

    assign out_fire = last_valid && out_ready;

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (out_fire && last_cc) begin
            zf_d = (last_res == '0);
            sf_d = last_res[MSB];
            of_d = last_of;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign cc_zf = zf_q;
    assign cc_sf = sf_q;
    assign cc_of = of_q;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// tb_alu_cc_pipe
//   Directed bench for alu_cc_pipe. Two instances (STAGES=2 and STAGES=1)
//   share one stimulus; each step checks only the instance under test.

module tb_alu_cc_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic        out_ready;

    logic        in_ready2, out_valid2, overflow2, zf2, sf2, of2;
    logic [63:0] out2;
    logic        in_ready1, out_valid1, overflow1, zf1, sf1, of1;
    logic [63:0] out1;

    int passed;
    int failed;
    int total;

    logic [63:0] exp_r [64];
    logic        exp_o [64];

    alu_cc_pipe #(.WIDTH(64), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .control(control), .a(a), .b(b), .set_cc(set_cc),
        .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
        .overflow(overflow2), .cc_zf(zf2), .cc_sf(sf2), .cc_of(of2)
    );

    alu_cc_pipe #(.WIDTH(64), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .control(control), .a(a), .b(b), .set_cc(set_cc),
        .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
        .overflow(overflow1), .cc_zf(zf1), .cc_sf(sf1), .cc_of(of1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: overflow derived from a 65-bit signed result.
    task automatic model(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic o);
        logic [64:0] wide;
        wide = '0;
        o    = 1'b0;
        case (op)
            2'd0: begin wide = {x[63], x} + {y[63], y}; r = wide[63:0]; o = wide[64] != wide[63]; end
            2'd1: begin wide = {x[63], x} - {y[63], y}; r = wide[63:0]; o = wide[64] != wide[63]; end
            2'd2: r = x & y;
            default: r = x ^ y;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; set_cc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; control = 2'd0;
        a = '0; b = '0; set_cc = 1'b0; out_ready = 1'b0;
        passed = 0; failed = 0; total = 0;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_in_ready",  in_ready2,  1'b1);
        chk("rst_out_valid", out_valid2, 1'b0);
        chk("rst_out",       out2,       64'd0);
        chk("rst_overflow",  overflow2,  1'b0);
        chk("rst_zf",        zf2,        1'b1);
        chk("rst_sf",        sf2,        1'b0);
        chk("rst_of",        of2,        1'b0);
        chk("rst1_in_ready", in_ready1,  1'b1);
        chk("rst1_out_valid", out_valid1, 1'b0);

        // ---------------- 1: ADD overflow, latency 2 ----------------
        @(negedge clk);
        in_valid = 1'b1; control = 2'd0; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1;
        set_cc = 1'b1; out_ready = 1'b1;
        #1 chk("t1_in_ready", in_ready2, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("t1_lat_not_yet", out_valid2, 1'b0);
        @(negedge clk);
        #1;
        chk("t1_out_valid", out_valid2, 1'b1);
        chk("t1_out",       out2,       64'h8000_0000_0000_0000);
        chk("t1_overflow",  overflow2,  1'b1);
        chk("t1_zf_before", zf2,        1'b1);
        @(negedge clk);
        #1;
        chk("t1_zf", zf2, 1'b0);
        chk("t1_sf", sf2, 1'b1);
        chk("t1_of", of2, 1'b1);
        chk("t1_drained", out_valid2, 1'b0);

        // ---------------- 2: SUB zero, then XOR without set_cc ----------------
        @(negedge clk);
        in_valid = 1'b1; control = 2'd1; a = 64'd5; b = 64'd5; set_cc = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t2_sub_valid", out_valid2, 1'b1);
        chk("t2_sub_out",   out2,       64'd0);
        chk("t2_sub_ovf",   overflow2,  1'b0);
        @(negedge clk);
        #1;
        chk("t2_zf", zf2, 1'b1);
        chk("t2_sf", sf2, 1'b0);
        chk("t2_of", of2, 1'b0);
        in_valid = 1'b1; control = 2'd3; a = 64'hF0; b = 64'hFF; set_cc = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t2_xor_valid", out_valid2, 1'b1);
        chk("t2_xor_out",   out2,       64'h0F);
        @(negedge clk);
        #1;
        chk("t2_xor_zf_hold", zf2, 1'b1);
        chk("t2_xor_sf_hold", sf2, 1'b0);
        chk("t2_drained", out_valid2, 1'b0);

        // ---------------- 3: 64-beat stream ----------------
        out_ready = 1'b1;
        for (int c = 0; c < 66; c++) begin
            @(negedge clk);
            if (c < 64) begin
                in_valid = 1'b1;
                control  = c[1:0];
                a        = 64'(63 - c);
                b        = 64'd63;
                set_cc   = 1'b0;
                model(control, a, b, exp_r[c], exp_o[c]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 64) chk("t3_in_ready", in_ready2, 1'b1);
            if (c >= 2) begin
                chk("t3_out_valid", out_valid2, 1'b1);
                chk("t3_out",       out2,       exp_r[c-2]);
                chk("t3_overflow",  overflow2,  exp_o[c-2]);
            end else begin
                chk("t3_fill", out_valid2, 1'b0);
            end
        end
        @(negedge clk);
        #1 chk("t3_drained", out_valid2, 1'b0);

        // ---------------- 4: backpressure ----------------
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; control = 2'd0; a = 64'd1; b = 64'd1; set_cc = 1'b0;
        #1 chk("t4_acc0", in_ready2, 1'b1);
        @(negedge clk);
        a = 64'd2; b = 64'd2;
        #1;
        chk("t4_acc1",     in_ready2,  1'b1);
        chk("t4_no_out_yet", out_valid2, 1'b0);
        @(negedge clk);
        a = 64'd3; b = 64'd3;
        #1;
        chk("t4_full",    in_ready2,  1'b0);
        chk("t4_valid",   out_valid2, 1'b1);
        chk("t4_out",     out2,       64'd2);
        @(negedge clk);
        #1;
        chk("t4_still_full", in_ready2,  1'b0);
        chk("t4_hold_valid", out_valid2, 1'b1);
        chk("t4_hold_out",   out2,       64'd2);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t4_ready_comb", in_ready2, 1'b1);
        chk("t4_out_2",      out2,      64'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t4_valid_4", out_valid2, 1'b1);
        chk("t4_out_4",   out2,       64'd4);
        @(negedge clk);
        #1;
        chk("t4_valid_6", out_valid2, 1'b1);
        chk("t4_out_6",   out2,       64'd6);
        @(negedge clk);
        #1 chk("t4_drained", out_valid2, 1'b0);

        // ---------------- 5: reset mid-flight ----------------
        @(negedge clk);
        in_valid = 1'b1; control = 2'd1; a = 64'd0; b = 64'd1; set_cc = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t5_pre_zf", zf2, 1'b0);
        chk("t5_pre_sf", sf2, 1'b1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; control = 2'd0; a = 64'd10; b = 64'd10;
        @(negedge clk);
        a = 64'd20; b = 64'd20;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t5_inflight_valid", out_valid2, 1'b1);
        chk("t5_inflight_out",   out2,       64'd20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("t5_out_valid", out_valid2, 1'b0);
        chk("t5_in_ready",  in_ready2,  1'b1);
        chk("t5_zf",        zf2,        1'b1);
        chk("t5_sf",        sf2,        1'b0);
        chk("t5_of",        of2,        1'b0);
        chk("t5_out",       out2,       64'd0);
        chk("t5_overflow",  overflow2,  1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk("t5_no_stale", out_valid2, 1'b0);
        end

        // ---------------- 6: STAGES=1 ----------------
        do_reset();
        chk("t6_rst_valid", out_valid1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; control = 2'd0; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1;
        set_cc = 1'b1; out_ready = 1'b1;
        #1 chk("t6a_in_ready", in_ready1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t6a_valid",     out_valid1, 1'b1);
        chk("t6a_out",       out1,       64'h8000_0000_0000_0000);
        chk("t6a_overflow",  overflow1,  1'b1);
        chk("t6a_zf_before", zf1,        1'b1);
        @(negedge clk);
        #1;
        chk("t6a_zf", zf1, 1'b0);
        chk("t6a_sf", sf1, 1'b1);
        chk("t6a_of", of1, 1'b1);
        chk("t6a_drained", out_valid1, 1'b0);

        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; control = 2'd0; a = 64'd1; b = 64'd1; set_cc = 1'b0;
        #1 chk("t6b_acc0", in_ready1, 1'b1);
        @(negedge clk);
        a = 64'd2; b = 64'd2;
        #1;
        chk("t6b_full",  in_ready1,  1'b0);
        chk("t6b_valid", out_valid1, 1'b1);
        chk("t6b_out",   out1,       64'd2);
        @(negedge clk);
        #1;
        chk("t6b_still_full", in_ready1, 1'b0);
        chk("t6b_hold_out",   out1,      64'd2);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t6b_ready_comb", in_ready1, 1'b1);
        chk("t6b_out_2",      out1,      64'd2);
        @(negedge clk);
        a = 64'd3; b = 64'd3;
        #1;
        chk("t6b_valid_4", out_valid1, 1'b1);
        chk("t6b_out_4",   out1,       64'd4);
        chk("t6b_ready_4", in_ready1,  1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t6b_valid_6", out_valid1, 1'b1);
        chk("t6b_out_6",   out1,       64'd6);
        @(negedge clk);
        #1 chk("t6b_drained", out_valid1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
